// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port unified memory between instruction fetch
//            (IF) and load/store (DM). Accesses are serialised through an
//            IDLE/ISSUE/WAIT/RESP FSM that waits a fixed memory latency and
//            returns registered read data with a one-cycle ack. DM has
//            priority. A streak counter forces an IF grant after STARVE_LIM
//            consecutive DM grants, so fetch always makes progress.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int c_STK_W = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [c_CNT_W-1:0] c_LAT     = c_CNT_W'(MEM_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_STK_W-1:0] c_STARVE  = c_STK_W'(STARVE_LIM);
    localparam logic [c_STK_W-1:0] c_STK_ONE = c_STK_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic                r_owner_dm, w_owner_nxt;   // 1 = current access belongs to DM
    logic                r_we,       w_we_nxt;      // only ever set for DM stores
    logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata,    w_wdata_nxt;
    logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [c_STK_W-1:0]  r_streak,   w_streak_nxt;
    logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0]   r_dm_rdata, w_dm_rdata_nxt;
    logic                w_grant_if;

    // State register: a synchronous reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner_dm <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_streak   <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner_dm <= w_owner_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_streak   <= w_streak_nxt;
            r_if_rdata <= w_if_rdata_nxt;
            r_dm_rdata <= w_dm_rdata_nxt;
        end
    end

    // Next-state logic: grant decision in IDLE, latency countdown in WAIT.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner_dm;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_cnt_nxt      = r_cnt;
        w_streak_nxt   = r_streak;
        w_if_rdata_nxt = r_if_rdata;
        w_dm_rdata_nxt = r_dm_rdata;

        // IF wins when it is alone or when DM has used up its streak allowance.
        w_grant_if = if_req & (~dm_req | (r_streak == c_STARVE));

        case (r_state)
            S_IDLE: begin
                if (if_req | dm_req) begin
                    w_state_nxt = S_ISSUE;
                    if (w_grant_if) begin
                        w_owner_nxt  = 1'b0;
                        w_we_nxt     = 1'b0;
                        w_addr_nxt   = if_addr;
                        w_wdata_nxt  = '0;
                        w_streak_nxt = '0;
                    end else begin
                        w_owner_nxt = 1'b1;
                        w_we_nxt    = dm_we;
                        w_addr_nxt  = dm_addr;
                        w_wdata_nxt = dm_wdata;
                        if (!if_req) begin
                            w_streak_nxt = '0;
                        end else if (r_streak != c_STARVE) begin
                            w_streak_nxt = r_streak + c_STK_ONE;
                        end
                    end
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = c_LAT;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == c_CNT_ONE) begin
                    // Read data is valid this cycle; stores leave rdata untouched.
                    if (!r_we) begin
                        if (r_owner_dm) begin
                            w_dm_rdata_nxt = mem_rdata;
                        end else begin
                            w_if_rdata_nxt = mem_rdata;
                        end
                    end
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_en    = (r_state == S_ISSUE);
    assign mem_we    = (r_state == S_ISSUE) & r_owner_dm & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = (r_state == S_RESP) & ~r_owner_dm;
    assign dm_ack    = (r_state == S_RESP) &  r_owner_dm;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter. Instance u_dut
//            uses MEM_LAT=2/STARVE_LIM=4, instance u_dut1 uses MEM_LAT=1.
//            Each instance has a small memory model that drives valid data
//            only in the exact cycle it is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    // u_dut signals (MEM_LAT = 2)
    logic        if_req, if_ack, dm_req, dm_we, dm_ack, stall_if, stall_mem;
    logic        mem_en, mem_we;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // u_dut1 signals (MEM_LAT = 1)
    logic        if_req_b, if_ack_b, stall_if_b, stall_mem_b, dm_ack_b;
    logic        mem_en_b, mem_we_b;
    logic [31:0] if_addr_b, if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_LIM(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIM(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_ack(dm_ack_b), .dm_rdata(dm_rdata_b),
        .stall_if(stall_if_b), .stall_mem(stall_mem_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h2001_0045;
    endfunction

    // Memory model, latency 2: data valid only in the cycle two after mem_en.
    logic [1:0]  v0 = 2'b00;
    logic [31:0] a0_0 = 32'h0, a0_1 = 32'h0;
    always @(posedge clk) begin
        v0   <= {v0[0], mem_en};
        a0_0 <= mem_addr;
        a0_1 <= a0_0;
    end
    assign mem_rdata = v0[1] ? mem_f(a0_1) : 32'hBADB_AD00;

    // Memory model, latency 1.
    logic        v1 = 1'b0;
    logic [31:0] a1 = 32'h0;
    always @(posedge clk) begin
        v1 <= mem_en_b;
        a1 <= mem_addr_b;
    end
    assign mem_rdata_b = v1 ? mem_f(a1) : 32'hBADB_AD11;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        if_req_b = 1'b0; if_addr_b = 32'h0;
        repeat (3) next_cycle();
        #1;
        checks++;
        if ({mem_en, mem_we, if_ack, dm_ack, stall_if, stall_mem} !== 6'b0)
            $display("FAIL reset_ctrl got %b exp 000000",
                     {mem_en, mem_we, if_ack, dm_ack, stall_if, stall_mem});
        else passed++;
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0)
            $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        else passed++;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        #1;
        checks++;
        if ({mem_en, if_ack, dm_ack, mem_en_b, if_ack_b} !== 5'b0)
            $display("FAIL post_reset_idle got %b exp 00000",
                     {mem_en, if_ack, dm_ack, mem_en_b, if_ack_b});
        else passed++;
    endtask

    task automatic test_if_only();
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h0000_0040; end
            if (c == 5) if_req = 1'b0;
            #1;
            checks++;
            if ({mem_en, if_ack, stall_if} !== {c == 1, c == 4, c < 4})
                $display("FAIL if_only_c%0d en/ack/stall got %b exp %b", c,
                         {mem_en, if_ack, stall_if}, {c == 1, c == 4, c < 4});
            else passed++;
            if (c == 1) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 32'h40, 32'h0})
                    $display("FAIL if_only_issue got we=%b a=%h d=%h exp 0/40/0",
                             mem_we, mem_addr, mem_wdata);
                else passed++;
            end
            if (c == 4) begin
                checks++;
                if (if_rdata !== 32'h2001_0005)
                    $display("FAIL if_only_rdata got %h exp 20010005", if_rdata);
                else passed++;
            end
        end
    endtask

    task automatic test_priority();
        for (int c = 0; c <= 10; c++) begin
            next_cycle();
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h80;
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
            end
            if (c == 5)  dm_req = 1'b0;
            if (c == 10) if_req = 1'b0;
            #1;
            checks++;
            if ({mem_en, dm_ack, if_ack, stall_if} !==
                {(c == 1) || (c == 6), c == 4, c == 9, c <= 8})
                $display("FAIL prio_c%0d en/dack/iack/stall got %b exp %b", c,
                         {mem_en, dm_ack, if_ack, stall_if},
                         {(c == 1) || (c == 6), c == 4, c == 9, c <= 8});
            else passed++;
            if (c == 1 || c == 6) begin
                checks++;
                if (mem_addr !== ((c == 1) ? 32'h100 : 32'h80))
                    $display("FAIL prio_addr_c%0d got %h exp %h", c, mem_addr,
                             (c == 1) ? 32'h100 : 32'h80);
                else passed++;
            end
            if (c == 4) begin
                checks++;
                if (dm_rdata !== 32'h2001_0145)
                    $display("FAIL prio_dm_rdata got %h exp 20010145", dm_rdata);
                else passed++;
            end
            if (c == 9) begin
                checks++;
                if (if_rdata !== 32'h2001_00C5)
                    $display("FAIL prio_if_rdata got %h exp 200100c5", if_rdata);
                else passed++;
            end
        end
    endtask

    task automatic test_store();
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            if (c == 0) begin
                dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
            end
            if (c == 5) begin dm_req = 1'b0; dm_we = 1'b0; end
            #1;
            checks++;
            if ({mem_en, mem_we, dm_ack, stall_mem} !== {c == 1, c == 1, c == 4, c < 4})
                $display("FAIL store_c%0d en/we/ack/stall got %b exp %b", c,
                         {mem_en, mem_we, dm_ack, stall_mem}, {c == 1, c == 1, c == 4, c < 4});
            else passed++;
            if (c == 1) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {32'h200, 32'hDEAD_BEEF})
                    $display("FAIL store_issue got a=%h d=%h exp 200/deadbeef",
                             mem_addr, mem_wdata);
                else passed++;
            end
            if (c == 4) begin
                checks++;
                if (dm_rdata !== 32'h2001_0145)
                    $display("FAIL store_rdata_kept got %h exp 20010145", dm_rdata);
                else passed++;
            end
        end
    endtask

    task automatic test_starvation();
        logic [31:0] grants [10];
        int n = 0;
        for (int i = 0; i < 10; i++) grants[i] = 32'h0;
        next_cycle();
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int c = 0; c < 150 && n < 10; c++) begin
            next_cycle();
            #1;
            if (mem_en) begin
                grants[n] = mem_addr;
                n++;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (grants[i] !== ((i % 5 == 4) ? 32'h40 : 32'h300))
                $display("FAIL starve_grant%0d got %h exp %h", i, grants[i],
                         (i % 5 == 4) ? 32'h40 : 32'h300);
            else passed++;
        end
        repeat (8) next_cycle();
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            next_cycle();
            if (c == 0) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; end
            if (c == 2) rst = 1'b1;
            if (c == 3) begin rst = 1'b0; dm_req = 1'b0; end
            #1;
        end
        checks++;
        if ({mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata} !== 132'h0)
            $display("FAIL rst_mid_outputs got en=%b ack=%b a=%h ir=%h dr=%h exp all 0",
                     mem_en, dm_ack, mem_addr, if_rdata, dm_rdata);
        else passed++;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            #1;
            if (dm_ack || mem_en) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL rst_mid_no_ack got %b exp 0", seen);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int k = 0;
        logic prev_ack = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            next_cycle();
            if (c == 0) begin if_req_b = 1'b1; if_addr_b = 32'h1000; end
            if (prev_ack) begin
                k++;
                if_addr_b = 32'h1000 + 32'(4 * k);
                if (c == 16) if_req_b = 1'b0;
            end
            #1;
            if (c < 16) begin
                checks++;
                if (if_ack_b !== (c % 4 == 3))
                    $display("FAIL b2b_ack_c%0d got %b exp %b", c, if_ack_b, c % 4 == 3);
                else passed++;
                if (c % 4 == 3) begin
                    checks++;
                    if (if_rdata_b !== mem_f(32'h1000 + 32'(4 * k)))
                        $display("FAIL b2b_rdata%0d got %h exp %h", k, if_rdata_b,
                                 mem_f(32'h1000 + 32'(4 * k)));
                    else passed++;
                end
            end
            prev_ack = if_ack_b;
        end
        repeat (4) next_cycle();
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_priority();
        test_store();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
